// File: rtl/gpr_file_sb_pkg.sv
// gpr_file_sb_pkg: shared GPR constants and slicing macros for the packed port buses.
`ifndef GPR_FILE_SB_MACROS
`define GPR_FILE_SB_MACROS
`define GPR_UNPACK(bus, i, w) bus[(i)*(w) +: (w)]
`define GPR_PACK(bus, i, w) bus[(i)*(w) +: (w)]
`endif

package gpr_file_sb_pkg;
    localparam int GPR_NUM_W = 5;
    localparam int GPR_COUNT = 32;
    localparam logic [63:0] GPR_ZERO = '0;
endpackage

// File: rtl/gpr_bypass_mux.sv
// gpr_bypass_mux: per-read-port write bypass, highest-index write port wins.
module gpr_bypass_mux
    import gpr_file_sb_pkg::*;
#(
    parameter int NR_WRITE = 2,
    parameter int DATA_W   = 32
) (
    input  logic                          en_i,
    input  logic [GPR_NUM_W-1:0]          rd_num_i,
    input  logic [NR_WRITE-1:0]           wr_en_i,
    input  logic [NR_WRITE*GPR_NUM_W-1:0] wr_num_i,
    input  logic [NR_WRITE*DATA_W-1:0]    wr_data_i,
    input  logic [DATA_W-1:0]             stored_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          hit_o
);
    always_comb begin
        hit_o  = 1'b0;
        data_o = stored_i;
        for (int w = 0; w < NR_WRITE; w++) begin
            if (en_i && wr_en_i[w] && `GPR_UNPACK(wr_num_i, w, GPR_NUM_W) == rd_num_i) begin
                hit_o  = 1'b1;
                data_o = `GPR_UNPACK(wr_data_i, w, DATA_W);
            end
        end
        if (rd_num_i == '0) begin
            hit_o  = 1'b0;
            data_o = GPR_ZERO[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: multi-port GPR file with busy-bit scoreboard.
// REGFILE_FORWARD_EN compiles in the same-cycle write bypass and rd_busy suppression.
module gpr_file_sb
    import gpr_file_sb_pkg::*;
#(
    parameter int NR_READ  = 4,
    parameter int NR_WRITE = 2,
    parameter int NR_ALLOC = 2,
    parameter int DATA_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NR_READ*GPR_NUM_W-1:0]  rd_num,
    output logic [NR_READ*DATA_W-1:0]     rd_data,
    output logic [NR_READ-1:0]            rd_busy,
    input  logic [NR_WRITE-1:0]           wr_en,
    input  logic [NR_WRITE*GPR_NUM_W-1:0] wr_num,
    input  logic [NR_WRITE*DATA_W-1:0]    wr_data,
    input  logic [NR_ALLOC-1:0]           al_en,
    input  logic [NR_ALLOC*GPR_NUM_W-1:0] al_num,
    input  logic                          flush,
    output logic [GPR_COUNT-1:0]          busy_vec
);
    logic [DATA_W-1:0]    regs_q [GPR_COUNT];
    logic [DATA_W-1:0]    regs_d [GPR_COUNT];
    logic [GPR_COUNT-1:0] busy_q, busy_d;

    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NR_WRITE; w++)
            if (wr_en[w]) regs_d[`GPR_UNPACK(wr_num, w, GPR_NUM_W)] = `GPR_UNPACK(wr_data, w, DATA_W);
        regs_d[0] = '0;
    end

    // clears first, then sets, so a new producer beats a same-cycle writeback
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NR_WRITE; w++)
            if (wr_en[w]) busy_d[`GPR_UNPACK(wr_num, w, GPR_NUM_W)] = 1'b0;
        for (int a = 0; a < NR_ALLOC; a++)
            if (al_en[a]) busy_d[`GPR_UNPACK(al_num, a, GPR_NUM_W)] = 1'b1;
        busy_d    = flush ? '0 : busy_d;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NR_READ; i++) begin : g_rd
        logic [GPR_NUM_W-1:0] num;
        assign num = `GPR_UNPACK(rd_num, i, GPR_NUM_W);
`ifdef REGFILE_FORWARD_EN
        logic hit;
        gpr_bypass_mux #(
            .NR_WRITE(NR_WRITE),
            .DATA_W  (DATA_W)
        ) u_mux (
            .en_i     (rst),
            .rd_num_i (num),
            .wr_en_i  (wr_en),
            .wr_num_i (wr_num),
            .wr_data_i(wr_data),
            .stored_i (regs_q[num]),
            .data_o   (`GPR_PACK(rd_data, i, DATA_W)),
            .hit_o    (hit)
        );
        assign rd_busy[i] = busy_q[num] & ~hit;
`else
        assign `GPR_PACK(rd_data, i, DATA_W) = (num == '0) ? GPR_ZERO[DATA_W-1:0] : regs_q[num];
        assign rd_busy[i] = busy_q[num];
`endif
    end
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed self-checking bench for gpr_file_sb (either REGFILE_FORWARD_EN build).
module tb_gpr_file_sb;
    localparam int NR = 4, NW = 2, NA = 2, DW = 32;
`ifdef REGFILE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic [NR*5-1:0]  rd_num;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*5-1:0]  wr_num;
    logic [NW*DW-1:0] wr_data;
    logic [NA-1:0]    al_en;
    logic [NA*5-1:0]  al_num;
    logic             flush;
    logic [31:0]      busy_vec;

    int n_cmp = 0, n_err = 0;

    gpr_file_sb #(.NR_READ(NR), .NR_WRITE(NW), .NR_ALLOC(NA), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .al_en(al_en), .al_num(al_num), .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0;
        al_en = '0;
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    initial begin
        idle();
        rd_num = '0; wr_num = '0; wr_data = '0; al_num = '0;
        wr_en = 2'b01; wr_num[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF;
        al_en = 2'b01; al_num[4:0] = 5'd5; rd_num[4:0] = 5'd5;
        tick(); tick();
        chk("rst_rd_data", rd(0), 0);
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_rd_busy", rd_busy, 0);
        idle();
        rst = 1'b1;
        tick();
        chk("post_rst_r5", rd(0), 0);

        wr_en = 2'b11; wr_num = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_num[4:0] = 5'd7;
        #1 chk("dw_same_cycle", rd(0), FWD ? 32'h22 : 32'h0);
        tick(); idle();
        #1 chk("dw_next_cycle", rd(0), 32'h22);

        wr_en = 2'b11; wr_num = {5'd4, 5'd3}; wr_data = {32'hB, 32'hA};
        tick(); idle();
        rd_num = {5'd3, 5'd0, 5'd4, 5'd3};
        #1 chk("distinct_4port", rd_data, {32'hA, 32'h0, 32'hB, 32'hA});

        rd_num = {5'd0, 5'd0, 5'd0, 5'd9};
        al_en = 2'b01; al_num[4:0] = 5'd9;
        tick(); idle();
        #1 chk("alloc_rd_busy", rd_busy, 4'b0001);
        chk("alloc_busy_vec", busy_vec, 32'h1 << 9);
        wr_en = 2'b01; wr_num[4:0] = 5'd9; wr_data[31:0] = 32'h55;
        #1 chk("wb_rd_busy", rd_busy, FWD ? 4'b0000 : 4'b0001);
        chk("wb_rd_data", rd(0), FWD ? 32'h55 : 32'h0);
        tick(); idle();
        #1 chk("wb_busy_vec", busy_vec, 0);
        chk("wb_rd_data_next", rd(0), 32'h55);
        chk("wb_rd_busy_next", rd_busy, 0);

        al_en = 2'b01; al_num[4:0] = 5'd9;
        wr_en = 2'b01; wr_num[4:0] = 5'd9; wr_data[31:0] = 32'h66;
        tick(); idle();
        #1 chk("collide_busy_vec", busy_vec, 32'h1 << 9);
        chk("collide_data", rd(0), 32'h66);
        flush = 1'b1; al_en = 2'b10; al_num[9:5] = 5'd12;
        tick(); idle();
        #1 chk("flush_busy_vec", busy_vec, 0);

        al_en = 2'b01; al_num[4:0] = 5'd0;
        wr_en = 2'b01; wr_num[4:0] = 5'd0; wr_data[31:0] = 32'hFFFF;
        rd_num[4:0] = 5'd0;
        #1 chk("r0_same_cycle", rd(0), 0);
        tick(); idle();
        #1 chk("r0_busy_vec", busy_vec, 0);
        chk("r0_read", rd(0), 0);

        wr_en = 2'b10; wr_num[9:5] = 5'd6; wr_data[63:32] = 32'h77; rd_num[4:0] = 5'd6;
        #1 chk("r6_same_cycle", rd(0), FWD ? 32'h77 : 32'h0);
        tick(); idle();
        #1 chk("r6_next_cycle", rd(0), 32'h77);

        wr_en = 2'b01; wr_num[4:0] = 5'd10; wr_data[31:0] = 32'h99;
        al_en = 2'b01; al_num[4:0] = 5'd11;
        rd_num[4:0] = 5'd10; rd_num[9:5] = 5'd6;
        #1 rst = 1'b0;
        #1 chk("rst_async_r6", rd(1), 0);
        chk("rst_gate_r10", rd(0), 0);
        chk("rst_gate_busy", rd_busy, 0);
        tick(); idle();
        rst = 1'b1;
        #1 chk("rst_discard_r10", rd(0), 0);
        chk("rst_cleared_r6", rd(1), 0);
        chk("rst_busy_clear", busy_vec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised multi-port general-purpose register file with an integrated busy-bit scoreboard for the dual-issue ID stage. It replaces the fixed 4-read/2-write file with configurable read and write port counts. Write-port ordering is consistent: the highest-index port is the youngest and wins both the array write and the bypass. A per-register busy bit is set at issue, cleared at writeback and bulk-cleared on pipeline flush, so issue logic can stall on operands that are not ready.

## Interface
- NR_READ, default 4: read ports; range 1..8.
- NR_WRITE, default 2: write ports; port NR_WRITE-1 is the youngest; range 1..4.
- NR_ALLOC, default 2: busy-set (issue) ports; range 1..4.
- DATA_W, default 32: register width.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; release is synchronous to clk upstream.
- rd_num  in  NR_READ*5  packed read register numbers; port i occupies bits [5i+4:5i].
- rd_data  out  NR_READ*DATA_W  packed read data.
- rd_busy  out  NR_READ  operand not yet available.
- wr_en  in  NR_WRITE  write enables.
- wr_num  in  NR_WRITE*5  write register numbers.
- wr_data  in  NR_WRITE*DATA_W  write data.
- al_en  in  NR_ALLOC  mark destination busy at issue.
- al_num  in  NR_ALLOC*5  destination register numbers.
- flush  in  1  clear all busy bits.
- busy_vec  out  32  current busy bits; bit 0 is always 0.

## Operation
- Register 0 reads as zero and is never busy. Writes and allocates to r0 are ignored.
- Array write: every enabled port writes. When several ports target the same register, the highest-index port wins. Distinct targets all commit in the same cycle.
- Read, with REGFILE_FORWARD_EN defined:
  - rd_num = 0 returns 0.
  - Otherwise return wr_data of the highest-index enabled write port whose number matches.
  - If no port matches, return the stored value.
- rd_busy[i] = busy[rd_num[i]] and no enabled write port matches rd_num[i] in the same cycle.
- Busy update, evaluated per register in this priority order:
  1. flush clears all bits. Allocates in the same cycle are ignored.
  2. Any al_en hit sets the bit. Set wins over a same-cycle write clear, because a new producer has been issued.
  3. Otherwise any wr_en hit clears the bit.
- Reset (rst low): all registers are 0 and all busy bits are 0, immediately and asynchronously. While rst is low, the bypass is gated off, so rd_data = 0 and rd_busy = 0.

## Timing
- Reads are combinational from rd_num, wr_* and state. There are no stall cycles.
- A write is visible in the array on the cycle after wr_en. With forwarding enabled it is also visible in the same cycle.
- Busy set by al_en is visible on rd_busy and busy_vec on the next cycle.
- Busy cleared by wr_en:
  - rd_busy drops in the same cycle when forwarding is enabled.
  - busy_vec drops on the next cycle.
- Flush takes effect on the next edge.
- Reset asserted mid-operation discards any in-flight write on that edge.

## Configuration
- REGFILE_FORWARD_EN defined: the same-cycle write-to-read bypass and the same-cycle rd_busy suppression are compiled in.
- Not defined:
  - rd_data returns only the stored array value, so a write is seen one cycle later.
  - rd_busy = busy[rd_num] directly.
  - This gives a shorter combinational path. The issue logic then tolerates one extra stall cycle after each writeback.

## Structure
- Shared package/defines header holds:
  - the GPR number width (5) and register count (32);
  - the zero word;
  - the PACK/UNPACK array macros for the packed port buses.
- One sub-module: gpr_bypass_mux. It is instantiated per read port and takes rd_num, the write ports and the stored value. It produces rd_data and the hit indication using a highest-index-wins priority select.
- The scoreboard lives in the top level as a 32-bit register with next-state logic.

## Test plan
- Reset then read all ports: with rst low, write r5 = 0xDEADBEEF → rd_data = 0 and busy_vec = 0. After release, reading r5 returns 0.
- Same-cycle double write to the same register: wr_en = 2'b11, both wr_num = 7, data 0x11 and 0x22. Same-cycle read of r7 returns 0x22 (forwarding on). The next cycle, the array holds 0x22.
- Distinct double write: write r3 = 0xA and r4 = 0xB. The next cycle, all four read ports on {3,4,0,3} return {0xA, 0xB, 0, 0xA}.
- Scoreboard lifecycle: alloc r9 → the next cycle rd_busy = 1 on r9. Writing r9 = 0x55 → rd_busy = 0 in the same cycle with data 0x55, and busy_vec[9] = 0 the next cycle.
- Set/clear collision and flush:
  - Alloc r9 and write r9 in the same cycle → busy_vec[9] = 1.
  - Then flush together with alloc of r12 → busy_vec = 0.
- r0 handling and the forwarding-off build: alloc and write r0 → busy_vec[0] = 0 and read r0 returns 0. With REGFILE_FORWARD_EN undefined, a write of r6 = 0x77 is seen on rd_data only on the next cycle.
